// File: rtl/or_accum_8bit.sv
// ============================================================================
// Module   : or_accum_8bit
// Brief    : Streaming OR-reduction of byte frames with a one-entry result buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module or_accum_8bit #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         inA,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    input  logic               abort,
    output logic [7:0]         outY,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_any,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    localparam logic [COUNT_W-1:0] c_CNT_ONE = COUNT_W'(1);

    logic [1:0]         r_state;
    logic [7:0]         r_acc;
    logic [COUNT_W-1:0] r_cnt;
    logic [7:0]         r_outY;
    logic [COUNT_W-1:0] r_out_count;
    logic               r_out_any;
    logic               r_out_valid;

    logic               w_hold;
    logic               w_take;
    logic [7:0]         w_or;
    logic [COUNT_W-1:0] w_cnt_next;

    assign w_hold   = (r_state == c_ST_HOLD);
    assign in_ready = w_hold ? out_ready : 1'b1;
    assign w_take   = in_valid & in_ready & ~abort;

    // acc and cnt are held at zero outside ACCUM, so the first beat of a frame
    // and a continuation beat share the same merge and increment path.
    assign w_or       = r_acc | inA;
    assign w_cnt_next = (&r_cnt) ? r_cnt : (r_cnt + c_CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_acc       <= 8'h00;
            r_cnt       <= '0;
            r_outY      <= 8'h00;
            r_out_count <= '0;
            r_out_any   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_hold && out_ready) begin
                r_out_valid <= 1'b0;
                r_state     <= c_ST_IDLE;
            end

            // A pending result survives abort; only a partial frame is discarded.
            if (abort) begin
                if (!w_hold) begin
                    r_acc   <= 8'h00;
                    r_cnt   <= '0;
                    r_state <= c_ST_IDLE;
                end
            end else if (w_take) begin
                if (in_last) begin
                    r_outY      <= w_or;
                    r_out_count <= w_cnt_next;
                    r_out_any   <= |w_or;
                    r_out_valid <= 1'b1;
                    r_acc       <= 8'h00;
                    r_cnt       <= '0;
                    r_state     <= c_ST_HOLD;
                end else begin
                    r_acc   <= w_or;
                    r_cnt   <= w_cnt_next;
                    r_state <= c_ST_ACCUM;
                end
            end
        end
    end

    assign outY      = r_outY;
    assign out_count = r_out_count;
    assign out_any   = r_out_any;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_or_accum_8bit.sv
// ============================================================================
// Module   : tb_or_accum_8bit
// Brief    : Directed and random checks of or_accum_8bit against a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_or_accum_8bit;

    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [7:0]    inA;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          abort;
    logic [7:0]    outY;
    logic [CW-1:0] out_count;
    logic          out_any;
    logic          out_valid;
    logic          out_ready;

    or_accum_8bit #(.COUNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inA       (inA),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .abort     (abort),
        .outY      (outY),
        .out_count (out_count),
        .out_any   (out_any),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: bytes of the open frame, plus the pending result.
    logic [7:0] m_frame[$];
    logic       m_pend;
    logic [7:0] m_y;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(m_pend));
        check("in_ready", 32'(in_ready), m_pend ? 32'(out_ready) : 32'd1);
        if (m_pend) begin
            check("outY", 32'(outY), 32'(m_y));
            check("out_count", 32'(out_count), 32'(m_cnt));
            check("out_any", 32'(out_any), (m_y != 8'h00) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic model_clear();
        m_frame.delete();
        m_pend = 1'b0;
        m_y    = 8'h00;
        m_cnt  = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        input logic ab, input logic ordy);
        logic pend_before;
        logic acc;
        logic [7:0] r;
        @(negedge clk);
        in_valid  = v;
        inA       = d;
        in_last   = l;
        abort     = ab;
        out_ready = ordy;
        #1;
        check_outputs();
        pend_before = m_pend;
        acc = v && (m_pend ? ordy : 1'b1);
        @(posedge clk);
        if (pend_before && ordy) m_pend = 1'b0;
        if (ab) begin
            if (!pend_before) m_frame.delete();
        end else if (acc) begin
            m_frame.push_back(d);
            if (l) begin
                r = 8'h00;
                foreach (m_frame[i]) r = r | m_frame[i];
                m_y    = r;
                m_cnt  = (m_frame.size() > MAXC) ? MAXC : m_frame.size();
                m_pend = 1'b1;
                m_frame.delete();
            end
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_outY", 32'(outY), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_any", 32'(out_any), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; inA = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outY", 32'(outY), 32'd0);
        check("reset_out_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;

        // Single zero beat
        step(1, 8'h00, 1, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);

        // Three-beat frame
        step(1, 8'h01, 0, 0, 1);
        step(1, 8'h20, 0, 0, 1);
        step(1, 8'h80, 1, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);

        // Held result with backpressure, then same-cycle consume and reload
        step(1, 8'h0F, 1, 0, 0);
        repeat (4) step(1, 8'hF0, 1, 0, 0);
        step(1, 8'hF0, 1, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);

        // Abort drops partial frame and its own beat
        step(1, 8'h11, 0, 0, 1);
        step(1, 8'h22, 0, 0, 1);
        step(1, 8'h44, 0, 1, 1);
        step(1, 8'h08, 1, 0, 1);
        step(0, 8'h00, 0, 0, 1);

        // Abort while holding keeps the result
        step(1, 8'h3C, 1, 0, 0);
        step(1, 8'h99, 1, 1, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 1);

        // Counter saturation
        repeat (5) step(1, 8'h01, 0, 0, 1);
        step(1, 8'h01, 1, 0, 1);
        step(0, 8'h00, 0, 0, 1);

        // Asynchronous reset mid-frame and with a result pending
        step(1, 8'hAA, 0, 0, 1);
        async_reset();
        step(1, 8'h55, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        async_reset();
        step(1, 8'h55, 1, 0, 1);
        step(0, 8'h00, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic       v, l, ab, rd;
            logic [7:0] d;
            v  = ($urandom_range(0, 9) < 7);
            l  = ($urandom_range(0, 9) < 2);
            ab = ($urandom_range(0, 19) == 0);
            rd = ($urandom_range(0, 9) < 6);
            d  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            step(v, d, l, ab, rd);
        end
        step(0, 8'h00, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
